fixed_to_float_serial: RTL and testbench
========================================

FIXED_TO_FLOAT_SERIAL -- requirements
Module: fixed_to_float_serial

Interface
REQ-001 SHALL have parameter DATA_W, default 22, the input fixed-point width in bits, legal range 2..24.
REQ-002 SHALL have parameter FRAC_W, default 20, the number of fraction bits, legal range 0..DATA_W-1.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port enable, input, 1 bit, the conversion request, used as a level or a pulse.
REQ-006 SHALL have port data, input, DATA_W bits, a two's-complement fixed-point value (default Q2.20, value = data * 2^-FRAC_W).
REQ-007 SHALL have port result, output, 32 bits, the IEEE-754 single-precision result.
REQ-008 SHALL have port done, output, 1 bit, a one-cycle completion strobe.
REQ-009 SHALL have port busy, output, 1 bit, high while a conversion is in progress.

Function
REQ-010 SHALL register enable into enable_q every cycle, with enable_q reset to 0.
REQ-011 SHALL define a start as a rising edge with state IDLE, reset=0, enable=1 and enable_q=0.
REQ-012 SHALL ignore an enable held high after a start and SHALL NOT retrigger until enable has been sampled low.
REQ-013 SHALL, on a start, capture sign=data[DATA_W-1] and mag=|data| as a DATA_W-bit unsigned value, clear shift count s, and enter NORM.
REQ-014 SHALL represent the most-negative input as mag=2^(DATA_W-1), which is exact with no overflow.
REQ-015 SHALL have FSM states IDLE and NORM only, with busy=1 exactly when the state is NORM.
REQ-016 SHALL, in NORM with mag==0, write result=32'h00000000 (positive zero, sign dropped), pulse done and return to IDLE.
REQ-017 SHALL, in NORM with mag[DATA_W-1]==0 and mag!=0, shift mag left by 1 and increment s, one bit per cycle.
REQ-018 SHALL, in NORM with mag[DATA_W-1]==1, write result={sign, exp, mant}, pulse done and return to IDLE.
REQ-019 SHALL compute exp = 127 + (DATA_W-1-s) - FRAC_W as 8 bits.
REQ-020 SHALL form mant from mag[DATA_W-2:0] left-aligned into 23 bits and zero-filled; the conversion is exact with no rounding.
REQ-021 SHALL have latency L = s+1 edges from the start edge to the done edge: L=1 for zero or a full-scale magnitude, L=DATA_W for mag=1 (22 at defaults).
REQ-022 SHALL hold done high for exactly one cycle per accepted start.
REQ-023 SHALL hold result stable from the done edge until the next done edge.
REQ-024 SHALL leave result unchanged while busy=1.
REQ-025 SHALL accept a start in the cycle in which done=1, allowing back-to-back operation.
REQ-026 SHALL ignore changes on data after the start edge.
REQ-027 SHALL drop an enable rising edge that arrives while busy=1; that request is not queued.
REQ-028 SHALL use no combinational path from any input to done, busy or result.

Reset
REQ-029 SHALL, when reset=1 at a clock edge, set state=IDLE, result=32'h00000000, done=0, busy=0, enable_q=0, s=0 and mag=0.
REQ-030 SHALL abort any conversion in progress on reset, with no done pulse for the aborted request.
REQ-031 SHALL give reset priority over a start in the same cycle.
REQ-032 SHALL treat enable=1 on the first edge after reset deasserts as a start.

Verification
REQ-033 SHALL check: data=22'h100000 (1.0), enable pulse -> result=32'h3F800000, done after L=2, busy high for 2 cycles.
REQ-034 SHALL check: data=22'h300000 (-1.0) -> 32'hBF800000; data=22'h200000 (-2.0) -> 32'hC0000000 with L=1; data=22'h080000 (0.5) -> 32'h3F000000.
REQ-035 SHALL check: data=22'h000000 -> result=32'h00000000 with L=1; data=22'h000001 (2^-20) -> 32'h35800000 with L=22.
REQ-036 SHALL check: enable held high for 40 cycles -> exactly one done; after enable falls and rises again -> a second done; a rise while busy=1 is dropped.
REQ-037 SHALL check: reset asserted mid-NORM for data=22'h000001 -> next cycle result=0, busy=0, done stays 0; a new start then converts correctly.
REQ-038 SHALL check: back-to-back starts on done cycles over random data -> each result bit-exact against a real-to-float reference model.

Source files
------------

// File: rtl/fixed_to_float_serial.sv
// rtl/fixed_to_float_serial.sv - serial fixed-point to IEEE-754 single converter
module fixed_to_float_serial #(
    parameter int DATA_W = 22,
    parameter int FRAC_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] data,
    output logic [31:0]       result,
    output logic              done,
    output logic              busy
);

    // Exponent of a value whose leading one sits at bit DATA_W-1 after s shifts.
    localparam int EXP_BASE = 127 + DATA_W - 1 - FRAC_W;

    typedef enum logic {IDLE, NORM} state_t;

    state_t            state;
    logic              enable_q;
    logic              sign;
    logic [DATA_W-1:0] mag;
    logic [4:0]        s;
    logic [DATA_W-1:0] abs_data;
    logic [7:0]        exp_field;
    logic [22:0]       mant;

    // Magnitude of the two's-complement input; the most-negative code maps to 2^(DATA_W-1).
    always_comb begin
        abs_data = data[DATA_W-1] ? ((~data) + DATA_W'(1)) : data;
    end

    // Float fields from the normalised magnitude: hidden one dropped, fraction left-aligned.
    always_comb begin
        exp_field = 8'(EXP_BASE - int'(s));
        mant      = 23'(mag[DATA_W-2:0]) << (24 - DATA_W);
    end

    // Control FSM: capture on an enable rising edge, shift one bit per cycle until normalised.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            result   <= 32'h0000_0000;
            done     <= 1'b0;
            busy     <= 1'b0;
            enable_q <= 1'b0;
            s        <= '0;
            mag      <= '0;
            sign     <= 1'b0;
        end else begin
            enable_q <= enable;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !enable_q) begin
                        sign  <= data[DATA_W-1];
                        mag   <= abs_data;
                        s     <= '0;
                        state <= NORM;
                        busy  <= 1'b1;
                    end
                end
                NORM: begin
                    if (mag == '0) begin
                        result <= 32'h0000_0000;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (mag[DATA_W-1]) begin
                        result <= {sign, exp_field, mant};
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        mag <= mag << 1;
                        s   <= s + 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_float_serial.sv
// tb/tb_fixed_to_float_serial.sv - scoreboard bench for fixed_to_float_serial
module tb_fixed_to_float_serial;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [21:0] data = '0;
    logic [31:0] result;
    logic        done;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   busy_run = 0;

    fixed_to_float_serial #(.DATA_W(22), .FRAC_W(20)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .data   (data),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] ref_float(input logic [21:0] d);
        real        v;
        real        a;
        int         e;
        logic       sgn;
        logic [22:0] m;
        v = $itor($signed(d)) / 1048576.0;
        if (v == 0.0) return 32'h0;
        sgn = (v < 0.0);
        a = sgn ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m = 23'($rtoi((a - 1.0) * 8388608.0));
        return {sgn, 8'(e + 127), m};
    endfunction

    function automatic int lat_of(input logic [21:0] d);
        int m;
        int sh;
        m = $signed(d);
        if (m < 0) m = -m;
        if (m == 0) return 1;
        sh = 0;
        while (m < (1 << 21)) begin m = m * 2; sh++; end
        return sh + 1;
    endfunction

    // Monitor: pop and compare on every done; count busy cycles per conversion.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("latency", 32'(cyc - e.t0 - 1), 32'(e.lat));
                    check("busy_cycles", 32'(busy_run), 32'(e.lat));
                end
                busy_run = 0;
            end
        end
    end

    task automatic push_exp(input logic [31:0] r, input int l);
        exp_t e;
        e.res = r;
        e.lat = l;
        e.t0  = cyc;
        sb.push_back(e);
    endtask

    task automatic send(input logic [21:0] d, input logic [31:0] r, input int l, input bit push);
        @(negedge clk);
        #1;
        data   = d;
        enable = 1'b1;
        if (push) push_exp(r, l);
        @(negedge clk);
        #1;
        enable = 1'b0;
        data   = 22'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 32'(sb.size()), 32'h0);
        repeat (3) @(negedge clk);
    endtask

    logic [21:0] dir_data [6] = '{22'h100000, 22'h300000, 22'h200000, 22'h080000, 22'h000000, 22'h000001};
    logic [31:0] dir_res  [6] = '{32'h3F800000, 32'hBF800000, 32'hC0000000, 32'h3F000000, 32'h00000000, 32'h35800000};
    int          dir_lat  [6] = '{2, 2, 1, 3, 1, 22};

    initial begin
        logic [21:0] d;
        repeat (3) @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        #1 reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send(dir_data[i], dir_res[i], dir_lat[i], 1'b1);
            drain();
        end

        // Enable held high: one conversion only, then a fresh rise converts again.
        @(negedge clk);
        #1;
        data   = 22'h300000;
        enable = 1'b1;
        push_exp(32'hBF800000, 2);
        repeat (40) @(negedge clk);
        #1 enable = 1'b0;
        drain();
        send(22'h080000, 32'h3F000000, 3, 1'b1);
        drain();

        // A rise while busy is dropped.
        send(22'h000001, 32'h35800000, 22, 1'b1);
        repeat (5) @(negedge clk);
        #1;
        data   = 22'h100000;
        enable = 1'b1;
        @(negedge clk);
        #1 enable = 1'b0;
        drain();
        repeat (30) @(negedge clk);

        // Reset mid-conversion aborts; start on the first edge after reset.
        send(22'h000001, 32'h35800000, 22, 1'b1);
        repeat (5) @(negedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_result", result, 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        #1;
        reset  = 1'b0;
        enable = 1'b1;
        data   = 22'h080000;
        push_exp(32'h3F000000, 3);
        @(negedge clk);
        #1 enable = 1'b0;
        drain();

        // Back-to-back starts on done cycles over random data.
        d = 22'($urandom);
        send(d, ref_float(d), lat_of(d), 1'b1);
        for (int k = 0; k < 20; k++) begin
            for (int t = 0; t < 50 && !done; t++) @(negedge clk);
            check("b2b_done_seen", 32'(done), 32'h1);
            #1;
            d = (k % 5 == 0) ? 22'h200000 : 22'($urandom >> (k % 22));
            data   = d;
            enable = 1'b1;
            push_exp(ref_float(d), lat_of(d));
            @(negedge clk);
            #1 enable = 1'b0;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
